// File: rtl/wb_latency_ram_if.sv
// Pipelined Wishbone bus between an initiator and the latency-emulating RAM.
interface wb_latency_ram_if #(
  parameter int unsigned XLEN = 32
);

  logic              i_wb_stb;
  logic [XLEN-1:0]   i_addr;
  logic [XLEN-1:0]   i_data;
  logic              i_wb_we;
  logic [XLEN/8-1:0] i_wb_sel;
  logic [XLEN-1:0]   o_wb_data;
  logic              o_wb_stall;
  logic              o_wb_ack;
  logic              o_wb_err;

  modport master (
    output i_wb_stb,
    output i_addr,
    output i_data,
    output i_wb_we,
    output i_wb_sel,
    input  o_wb_data,
    input  o_wb_stall,
    input  o_wb_ack,
    input  o_wb_err
  );

  modport slave (
    input  i_wb_stb,
    input  i_addr,
    input  i_data,
    input  i_wb_we,
    input  i_wb_sel,
    output o_wb_data,
    output o_wb_stall,
    output o_wb_ack,
    output o_wb_err
  );

endinterface

// File: rtl/wb_latency_ram.sv
// Pipelined Wishbone slave RAM with a fixed response latency. Requests are queued
// with a countdown and performed at retire time, so memory order equals request order.
module wb_latency_ram #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter int unsigned      LATENCY     = 8,
  parameter int unsigned      MAX_PENDING = 4,
  parameter logic [XLEN-1:0]  BASE_ADDR   = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  wb_latency_ram_if.slave wb
);

  localparam int unsigned PtrW  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int unsigned CntW  = $clog2(MAX_PENDING) + 1;
  localparam int unsigned DownW = $clog2(LATENCY + 1);
  localparam int unsigned IdxW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned SelW  = XLEN / 8;

  // Request queue payload (no reset needed: only entries covered by count_q are live)
  logic [XLEN-1:0]  q_addr [MAX_PENDING];
  logic [XLEN-1:0]  q_data [MAX_PENDING];
  logic             q_we   [MAX_PENDING];
  logic [SelW-1:0]  q_sel  [MAX_PENDING];

  // Per-entry countdown; zero means the slot is idle
  logic [DownW-1:0] down_q [MAX_PENDING];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic             ack_q;
  logic             err_q;
  logic [XLEN-1:0]  rdata_q;

  logic [XLEN-1:0]  mem [DEPTH_WORDS];

  logic             stall;
  logic             accept;
  logic             retire;

  logic [XLEN-1:0]  head_addr;
  logic [XLEN-1:0]  head_data;
  logic             head_we;
  logic [SelW-1:0]  head_sel;
  logic [XLEN-1:0]  head_off;
  logic [IdxW-1:0]  word_idx;
  logic             in_range;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_PENDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Full queue stalls even if the head retires this cycle: no bypass path
  assign stall  = (count_q == CntW'(MAX_PENDING));
  assign accept = wb.i_wb_stb && !stall;
  // Constant latency means the head always expires first
  assign retire = (count_q != '0) && (down_q[rd_ptr_q] == DownW'(1));

  assign head_addr = q_addr[rd_ptr_q];
  assign head_data = q_data[rd_ptr_q];
  assign head_we   = q_we[rd_ptr_q];
  assign head_sel  = q_sel[rd_ptr_q];

  // Address decode of the retiring request; addresses below BASE_ADDR wrap and are rejected
  always_comb begin
    head_off = head_addr - BASE_ADDR;
    word_idx = head_off[IdxW+1:2];
    in_range = (head_addr >= BASE_ADDR) && ((head_off >> 2) < XLEN'(DEPTH_WORDS));
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (retire) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({accept, retire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue control state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Countdowns: load on accept, decrement while nonzero; reset drops pending work
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(MAX_PENDING); i++) begin
        down_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MAX_PENDING); i++) begin
        if (accept && (wr_ptr_q == PtrW'(i))) begin
          down_q[i] <= DownW'(LATENCY);
        end else if (down_q[i] != '0) begin
          down_q[i] <= down_q[i] - DownW'(1);
        end
      end
    end
  end

  // Capture request payload on accept
  always_ff @(posedge i_clk) begin
    if (accept) begin
      q_addr[wr_ptr_q] <= wb.i_addr;
      q_data[wr_ptr_q] <= wb.i_data;
      q_we[wr_ptr_q]   <= wb.i_wb_we;
      q_sel[wr_ptr_q]  <= wb.i_wb_sel;
    end
  end

  // Byte-lane write performed at retire time; contents survive reset
  always_ff @(posedge i_clk) begin
    if (retire && in_range && head_we) begin
      for (int b = 0; b < int'(SelW); b++) begin
        if (head_sel[b]) begin
          mem[word_idx][8*b +: 8] <= head_data[8*b +: 8];
        end
      end
    end
  end

  // Registered response: ack or err for one cycle, data only for in-range reads
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= retire && in_range;
      err_q   <= retire && !in_range;
      rdata_q <= (retire && in_range && !head_we) ? mem[word_idx] : '0;
    end
  end

  assign wb.o_wb_stall = stall;
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_err   = err_q;
  assign wb.o_wb_data  = rdata_q;

endmodule

// File: tb/tb_wb_latency_ram.sv
// Directed bench for wb_latency_ram: latency, byte lanes, full queue, range errors, reset.
module tb_wb_latency_ram;

  localparam int Lat = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int          edge_n;
    logic        ack;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t rq[$];

  wb_latency_ram_if #(.XLEN(32)) bus ();

  wb_latency_ram #(
    .XLEN        (32),
    .DEPTH_WORDS (1024),
    .LATENCY     (Lat),
    .MAX_PENDING (4),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .wb      (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor, sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (bus.o_wb_ack || bus.o_wb_err) begin
      rq.push_back('{edge_n: cyc, ack: bus.o_wb_ack, err: bus.o_wb_err, data: bus.o_wb_data});
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel);
    bus.i_wb_stb = 1'b1;
    bus.i_wb_we  = we;
    bus.i_addr   = addr;
    bus.i_data   = data;
    bus.i_wb_sel = sel;
  endtask

  task automatic idle_bus();
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    bus.i_addr   = '0;
    bus.i_data   = '0;
    bus.i_wb_sel = '0;
  endtask

  // Present a request until taken; returns the edge number that accepted it
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output int acc);
    int n;
    n = 0;
    drive(we, addr, data, sel);
    while (bus.o_wb_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 0, 1);
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic expect_resp(input string tag, input int exp_edge, input logic exp_ack,
                             input logic [31:0] exp_data);
    resp_t r;
    int    n;
    n = 0;
    while (rq.size() == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      check_eq({tag, "_timeout"}, 0, 1);
      return;
    end
    r = rq.pop_front();
    check_eq({tag, "_edge"}, r.edge_n, exp_edge);
    check_eq({tag, "_ackerr"}, {r.ack, r.err}, {exp_ack, ~exp_ack});
    check_eq({tag, "_data"}, r.data, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e0, e1, e2, k;
    int acc [6];

    idle_bus();
    #1;
    check_eq("rst_outs", {bus.o_wb_stall, bus.o_wb_ack, bus.o_wb_err, bus.o_wb_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle", {bus.o_wb_stall, bus.o_wb_ack, bus.o_wb_err, bus.o_wb_data}, 0);
    end

    // Write then read back, back to back
    send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, e0);
    send(1'b0, 32'h10, 32'h0, 4'hF, e1);
    idle_bus();
    check_eq("b2b_accept", e1 - e0, 1);
    expect_resp("wr10", e0 + Lat, 1'b1, 32'h0);
    expect_resp("rd10", e1 + Lat, 1'b1, 32'hDEAD_BEEF);

    // Byte lanes: 0x11223344 merged with 0xAABBCCDD on lanes 0 and 2
    send(1'b1, 32'h20, 32'h1122_3344, 4'hF, e0);
    send(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, e1);
    send(1'b0, 32'h20, 32'h0, 4'hF, e2);
    idle_bus();
    expect_resp("pre20", e0 + Lat, 1'b1, 32'h0);
    expect_resp("sel20", e1 + Lat, 1'b1, 32'h0);
    expect_resp("rd20", e2 + Lat, 1'b1, 32'h11BB_33DD);

    // Out of range, then in range; last valid word as boundary
    send(1'b0, 32'h1000, 32'h0, 4'hF, e0);
    send(1'b0, 32'h10, 32'h0, 4'hF, e1);
    idle_bus();
    expect_resp("oor", e0 + Lat, 1'b0, 32'h0);
    expect_resp("after_oor", e1 + Lat, 1'b1, 32'hDEAD_BEEF);
    send(1'b1, 32'hFFC, 32'h5A5A_0FFC, 4'hF, e0);
    send(1'b0, 32'hFFC, 32'h0, 4'hF, e1);
    idle_bus();
    expect_resp("wr_last", e0 + Lat, 1'b1, 32'h0);
    expect_resp("rd_last", e1 + Lat, 1'b1, 32'h5A5A_0FFC);

    // Preload six words for the full-queue test
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 32'h40 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, acc[i]);
    end
    idle_bus();
    for (int i = 0; i < 6; i++) expect_resp("preload", acc[i] + Lat, 1'b1, 32'h0);
    repeat (2) @(negedge clk);

    // Full queue: four accepts at k..k+3, stalled k+3..k+7, then k+9 and k+10
    k = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF);
      check_eq("fq_nostall", bus.o_wb_stall, 0);
      @(negedge clk);
    end
    drive(1'b0, 32'h50, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check_eq("fq_stall_hi", bus.o_wb_stall, 1);
      @(negedge clk);
    end
    check_eq("fq_stall_lo", bus.o_wb_stall, 0);
    @(negedge clk);
    drive(1'b0, 32'h54, 32'h0, 4'hF);
    check_eq("fq_6th_free", bus.o_wb_stall, 0);
    @(negedge clk);
    idle_bus();
    expect_resp("fq0", k + Lat, 1'b1, 32'hC0DE_0000);
    expect_resp("fq1", k + 1 + Lat, 1'b1, 32'hC0DE_0001);
    expect_resp("fq2", k + 2 + Lat, 1'b1, 32'hC0DE_0002);
    expect_resp("fq3", k + 3 + Lat, 1'b1, 32'hC0DE_0003);
    expect_resp("fq4", k + 9 + Lat, 1'b1, 32'hC0DE_0004);
    expect_resp("fq5", k + 10 + Lat, 1'b1, 32'hC0DE_0005);
    repeat (5) @(negedge clk);
    check_eq("fq_no_extra", rq.size(), 0);

    // Reset with three reads pending: all dropped, RAM kept
    send(1'b0, 32'h10, 32'h0, 4'hF, e0);
    send(1'b0, 32'h20, 32'h0, 4'hF, e1);
    send(1'b0, 32'h40, 32'h0, 4'hF, e2);
    idle_bus();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", {bus.o_wb_stall, bus.o_wb_ack, bus.o_wb_err, bus.o_wb_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("midrst_dropped", rq.size(), 0);
    check_eq("midrst_nostall", bus.o_wb_stall, 0);
    send(1'b0, 32'h10, 32'h0, 4'hF, e0);
    send(1'b0, 32'h20, 32'h0, 4'hF, e1);
    idle_bus();
    expect_resp("post_rst10", e0 + Lat, 1'b1, 32'hDEAD_BEEF);
    expect_resp("post_rst20", e1 + Lat, 1'b1, 32'h11BB_33DD);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
